// File: rtl/risc16_mem_arbiter_if.sv
// Bus bundle between the RISC16 core ports, the shared memory and the arbiter.
// slave is the arbiter's view; master is the core-plus-memory side.
interface risc16_mem_arbiter_if;
   logic [15:0] iaddr;
   logic        ioe;
   logic [15:0] idin;
   logic        i_ready;
   logic [15:0] daddr;
   logic [15:0] ddout;
   logic        doe;
   logic        dwe;
   logic [15:0] ddin;
   logic        d_ready;
   logic [15:0] maddr;
   logic [15:0] mdout;
   logic [15:0] mdin;
   logic        moe;
   logic        mwe;
   logic        busy;

   modport slave (
      input  iaddr, ioe, daddr, ddout, doe, dwe, mdin,
      output idin, i_ready, ddin, d_ready, maddr, mdout, moe, mwe, busy
   );

   modport master (
      output iaddr, ioe, daddr, ddout, doe, dwe, mdin,
      input  idin, i_ready, ddin, d_ready, maddr, mdout, moe, mwe, busy
   );
endinterface

// File: rtl/risc16_mem_arbiter.sv
// Shares one single-port memory between RISC16 fetch and data ports via a wait-state FSM.
// Define RISC16_ARB_RR_EN for round-robin arbitration instead of fixed data priority.
module risc16_mem_arbiter #(
   parameter int unsigned WAIT_CYCLES = 0
) (
   input logic                 clk,
   input logic                 rst,
   risc16_mem_arbiter_if.slave bus
);

   if (WAIT_CYCLES > 15) begin : g_wait_range
      $error("WAIT_CYCLES must be in 0..15");
   end

   localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        gnt_data_q, gnt_data_d;
   logic [15:0] maddr_q, maddr_d;
   logic [15:0] mdout_q, mdout_d;
   logic        moe_q, moe_d;
   logic        mwe_q, mwe_d;
   logic [15:0] idin_q, idin_d;
   logic [15:0] ddin_q, ddin_d;
   logic        i_ready_q, i_ready_d;
   logic        d_ready_q, d_ready_d;

   logic req_data, req_instr, pick_data;

   assign req_data  = bus.doe | bus.dwe;
   assign req_instr = bus.ioe;

`ifdef RISC16_ARB_RR_EN
   logic last_data_q, last_data_d;

   // On a tie, data wins only if instruction was granted last.
   assign pick_data = req_data & (~req_instr | ~last_data_q);
`else
   assign pick_data = req_data;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gnt_data_d = gnt_data_q;
      maddr_d    = maddr_q;
      mdout_d    = mdout_q;
      moe_d      = moe_q;
      mwe_d      = mwe_q;
      idin_d     = idin_q;
      ddin_d     = ddin_q;
      i_ready_d  = 1'b0;
      d_ready_d  = 1'b0;
`ifdef RISC16_ARB_RR_EN
      last_data_d = last_data_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (req_data || req_instr) begin
               gnt_data_d = pick_data;
               maddr_d    = pick_data ? bus.daddr : bus.iaddr;
               if (pick_data && bus.dwe) begin
                  mdout_d = bus.ddout;
               end
               // doe together with dwe is a write; the read is dropped.
               moe_d   = pick_data ? ~bus.dwe : 1'b1;
               mwe_d   = pick_data & bus.dwe;
               cnt_d   = WaitCnt;
               state_d = StAccess;
`ifdef RISC16_ARB_RR_EN
               last_data_d = pick_data;
`endif
            end
         end
         StAccess: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (moe_q) begin
                  if (gnt_data_q) begin
                     ddin_d = bus.mdin;
                  end else begin
                     idin_d = bus.mdin;
                  end
               end
               moe_d     = 1'b0;
               mwe_d     = 1'b0;
               i_ready_d = ~gnt_data_q;
               d_ready_d = gnt_data_q;
               state_d   = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         gnt_data_q <= 1'b0;
         maddr_q    <= 16'h0000;
         mdout_q    <= 16'h0000;
         moe_q      <= 1'b0;
         mwe_q      <= 1'b0;
         idin_q     <= 16'h0000;
         ddin_q     <= 16'h0000;
         i_ready_q  <= 1'b0;
         d_ready_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gnt_data_q <= gnt_data_d;
         maddr_q    <= maddr_d;
         mdout_q    <= mdout_d;
         moe_q      <= moe_d;
         mwe_q      <= mwe_d;
         idin_q     <= idin_d;
         ddin_q     <= ddin_d;
         i_ready_q  <= i_ready_d;
         d_ready_q  <= d_ready_d;
      end
   end

`ifdef RISC16_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         last_data_q <= 1'b0;
      end else begin
         last_data_q <= last_data_d;
      end
   end
`endif

   assign bus.maddr   = maddr_q;
   assign bus.mdout   = mdout_q;
   assign bus.moe     = moe_q;
   assign bus.mwe     = mwe_q;
   assign bus.idin    = idin_q;
   assign bus.ddin    = ddin_q;
   assign bus.i_ready = i_ready_q;
   assign bus.d_ready = d_ready_q;
   assign bus.busy    = (state_q != StIdle);

endmodule
